// File: rtl/usb_cd_pkg.sv
// Shared definitions for the usb_coder source arbiter: FSM encoding,
// conventional source slots and the default byte width.
package usb_cd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      ACTIVE = 2'd2
   } cd_state_t;

   localparam int SRC_CRS  = 0;
   localparam int SRC_CCWB = 1;
   localparam int DEF_DW   = 8;

endpackage

// File: rtl/usb_cd_arbiter_rr_pick.sv
// Combinational one-hot picker: round-robin starting after ptr, or
// fixed priority (lowest index) when rr_en is low.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   input  logic          rr_en,
   output logic [N-1:0]  onehot
);

   logic found_s;

   // first requester in search order; constant indices keep the mux X-free
   always_comb begin
      onehot  = '0;
      found_s = 1'b0;
      if (rr_en) begin
         for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
               if (!found_s && req[i] && (i == ((int'(ptr) + k) % N))) begin
                  onehot[i] = 1'b1;
                  found_s   = 1'b1;
               end else begin
                  found_s   = found_s;
               end
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (!found_s && req[i]) begin
               onehot[i] = 1'b1;
               found_s   = 1'b1;
            end else begin
               found_s   = found_s;
            end
         end
      end
   end

endmodule

// File: rtl/usb_cd_arbiter.sv
// N-source arbiter in front of usb_coder: queues packet starts, grants one
// source at a time and routes its byte stream until pck_sent or a stall timeout.
module usb_cd_arbiter
   import usb_cd_pkg::*;
#(
   parameter int N_SRC      = 4,
   parameter int DW         = DEF_DW,
   parameter int RR_EN      = 1,
   parameter int TMO_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [N_SRC-1:0]    tx_start_srcs,
   input  logic [N_SRC*DW-1:0] src_bytes,
   input  logic [N_SRC-1:0]    src_last_byte,
   input  logic                usb_rdreq,
   input  logic                pck_sent,
   input  logic                ovr_clr,
   output logic                cd_tx_start,
   output logic [DW-1:0]       cd_d,
   output logic                cd_last_byte,
   output logic [N_SRC-1:0]    src_rdreqs,
   output logic [N_SRC-1:0]    grant,
   output logic                busy,
   output logic [N_SRC-1:0]    pending,
   output logic [N_SRC-1:0]    overrun,
   output logic                tmo_err
);

   localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int TW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
   localparam bit TMO_EN = (TMO_CYCLES != 0);
   localparam logic [TW-1:0] TMO_LAST = (TMO_CYCLES > 0) ? TW'(TMO_CYCLES - 1) : '0;

   cd_state_t        state_r, state_nxt_s;
   logic [N_SRC-1:0] grant_r, grant_nxt_s;
   logic [N_SRC-1:0] pending_r, overrun_r;
   logic [N_SRC-1:0] pick_s, take_s;
   logic [PW-1:0]    ptr_r, ptr_nxt_s, pick_idx_s;
   logic [TW-1:0]    tmo_cnt_r, tmo_cnt_nxt_s;
   logic             tx_start_r, tmo_err_r, tmo_hit_s;

   rr_pick #(.N(N_SRC), .PW(PW)) u_pick (
      .req    (pending_r),
      .ptr    (ptr_r),
      .rr_en  (RR_EN != 0),
      .onehot (pick_s)
   );

   // index of the picked source, for the round-robin pointer
   always_comb begin
      pick_idx_s = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pick_s[i]) begin
            pick_idx_s = PW'(i);
         end else begin
            pick_idx_s = pick_idx_s;
         end
      end
   end

   // next-state, grant, pointer and stall-counter decisions
   always_comb begin
      state_nxt_s   = state_r;
      grant_nxt_s   = grant_r;
      ptr_nxt_s     = ptr_r;
      take_s        = '0;
      tmo_cnt_nxt_s = tmo_cnt_r;
      tmo_hit_s     = 1'b0;
      case (state_r)
         IDLE: begin
            tmo_cnt_nxt_s = '0;
            if (|pending_r) begin
               take_s      = pick_s;
               grant_nxt_s = pick_s;
               ptr_nxt_s   = pick_idx_s;
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            tmo_cnt_nxt_s = '0;
            state_nxt_s   = ACTIVE;
         end
         ACTIVE: begin
            // end of packet beats a coincident timeout
            if (pck_sent) begin
               grant_nxt_s = '0;
               state_nxt_s = IDLE;
            end else if (TMO_EN && !usb_rdreq && (tmo_cnt_r == TMO_LAST)) begin
               grant_nxt_s = '0;
               tmo_hit_s   = 1'b1;
               state_nxt_s = IDLE;
            end else if (usb_rdreq) begin
               tmo_cnt_nxt_s = '0;
            end else begin
               tmo_cnt_nxt_s = tmo_cnt_r + TW'(1'b1);
            end
         end
         default: begin
            grant_nxt_s = '0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // grant, request queue, overrun flags, counter and output pulses
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         grant_r    <= '0;
         pending_r  <= '0;
         overrun_r  <= '0;
         ptr_r      <= PW'(N_SRC - 1);
         tmo_cnt_r  <= '0;
         tx_start_r <= 1'b0;
         tmo_err_r  <= 1'b0;
      end else begin
         grant_r    <= grant_nxt_s;
         pending_r  <= (pending_r & ~take_s) | tx_start_srcs;
         overrun_r  <= (overrun_r & {N_SRC{~ovr_clr}}) | (tx_start_srcs & pending_r & ~take_s);
         ptr_r      <= ptr_nxt_s;
         tmo_cnt_r  <= tmo_cnt_nxt_s;
         tx_start_r <= (state_nxt_s == START);
         tmo_err_r  <= tmo_hit_s;
      end
   end

   // byte mux: OR of one-hot-gated lanes, zero when nothing is granted
   always_comb begin
      cd_d = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_r[i]) begin
            cd_d = cd_d | src_bytes[i*DW +: DW];
         end else begin
            cd_d = cd_d;
         end
      end
   end

   assign cd_last_byte = (|(grant_r & src_last_byte)) && (state_r == ACTIVE);
   assign src_rdreqs   = grant_r & {N_SRC{usb_rdreq}};
   assign grant        = grant_r;
   assign busy         = (state_r == START) || (state_r == ACTIVE);
   assign pending      = pending_r;
   assign overrun      = overrun_r;
   assign cd_tx_start  = tx_start_r;
   assign tmo_err      = tmo_err_r;

endmodule

// File: tb/tb_usb_cd_arbiter.sv
// Directed bench: a round-robin instance (0) and a fixed-priority instance (1),
// expected grants and bytes queued at stimulus time and popped at DUT output.
module tb_usb_cd_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk;
   logic n_rst;
   logic [1:0][N-1:0]    tx_s, last_s;
   logic [1:0][N*DW-1:0] bytes_s;
   logic [1:0]           rdreq_s, pck_s, clr_s;
   logic [1:0]           start_o, last_o, busy_o, tmo_o;
   logic [1:0][DW-1:0]   d_o;
   logic [1:0][N-1:0]    rdreqs_o, grant_o, pend_o, ovr_o;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   logic [N-1:0]  exp_g_q[$];
   logic [DW-1:0] exp_d_q[$];
   logic [N-1:0]  cur_g;

   usb_cd_arbiter #(.N_SRC(N), .DW(DW), .RR_EN(1), .TMO_CYCLES(16)) dut_rr (
      .clk(clk), .n_rst(n_rst), .tx_start_srcs(tx_s[0]), .src_bytes(bytes_s[0]),
      .src_last_byte(last_s[0]), .usb_rdreq(rdreq_s[0]), .pck_sent(pck_s[0]),
      .ovr_clr(clr_s[0]), .cd_tx_start(start_o[0]), .cd_d(d_o[0]),
      .cd_last_byte(last_o[0]), .src_rdreqs(rdreqs_o[0]), .grant(grant_o[0]),
      .busy(busy_o[0]), .pending(pend_o[0]), .overrun(ovr_o[0]), .tmo_err(tmo_o[0])
   );

   usb_cd_arbiter #(.N_SRC(N), .DW(DW), .RR_EN(0), .TMO_CYCLES(16)) dut_fp (
      .clk(clk), .n_rst(n_rst), .tx_start_srcs(tx_s[1]), .src_bytes(bytes_s[1]),
      .src_last_byte(last_s[1]), .usb_rdreq(rdreq_s[1]), .pck_sent(pck_s[1]),
      .ovr_clr(clr_s[1]), .cd_tx_start(start_o[1]), .cd_d(d_o[1]),
      .cd_last_byte(last_o[1]), .src_rdreqs(rdreqs_o[1]), .grant(grant_o[1]),
      .busy(busy_o[1]), .pending(pend_o[1]), .overrun(ovr_o[1]), .tmo_err(tmo_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   function automatic int oh2i(input logic [N-1:0] g);
      int r = 0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) r = i;
      end
      return r;
   endfunction

   // wait (bounded) for cd_tx_start, compare grant to scoreboard, step into ACTIVE
   task automatic wait_grant(input int d, input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (start_o[d]) seen = 1'b1;
         else tick();
      end
      chk({tag, "_start_seen"}, 32'(seen), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(exp_g_q.size() != 0), 32'd1);
      cur_g = (exp_g_q.size() != 0) ? exp_g_q.pop_front() : 4'b0000;
      chk({tag, "_grant"}, 32'(grant_o[d]), 32'(cur_g));
      tick();
      chk({tag, "_busy_active"}, 32'(busy_o[d]), 32'd1);
      chk({tag, "_start_1cyc"}, 32'(start_o[d]), 32'd0);
   endtask

   // one byte through the granted lane, then pck_sent (with optional re-requests)
   task automatic finish_pkt(input int d, input logic [N-1:0] re, input string tag);
      logic [DW-1:0] b;
      logic [DW-1:0] e;
      int k;
      b = DW'($urandom_range(0, 255));
      k = oh2i(cur_g);
      bytes_s[d][k*DW +: DW] = b;
      rdreq_s[d] = 1'b1;
      exp_d_q.push_back(b);
      #1;
      e = exp_d_q.pop_front();
      chk({tag, "_cd_d"}, 32'(d_o[d]), 32'(e));
      chk({tag, "_rdreqs"}, 32'(rdreqs_o[d]), 32'(cur_g));
      tick();
      rdreq_s[d] = 1'b0;
      pck_s[d]   = 1'b1;
      tx_s[d]    = re;
      tick();
      pck_s[d]   = 1'b0;
      tx_s[d]    = 4'b0000;
      chk({tag, "_grant_drop"}, 32'(grant_o[d]), 32'd0);
      chk({tag, "_idle"}, 32'(busy_o[d]), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] e;
      int hit;
      int starts;
      n_rst   = 1'b0;
      tx_s    = '0;
      last_s  = '0;
      bytes_s = {2{32'hC3C3_C3C3}};
      rdreq_s = 2'b00;
      pck_s   = 2'b00;
      clr_s   = 2'b00;
      do_reset();

      // reset state, with rdreq held to show no source sees it while idle
      rdreq_s = 2'b11;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d_grant", d), 32'(grant_o[d]), 32'd0);
         chk($sformatf("rst%0d_pending", d), 32'(pend_o[d]), 32'd0);
         chk($sformatf("rst%0d_overrun", d), 32'(ovr_o[d]), 32'd0);
         chk($sformatf("rst%0d_busy", d), 32'(busy_o[d]), 32'd0);
         chk($sformatf("rst%0d_start", d), 32'(start_o[d]), 32'd0);
         chk($sformatf("rst%0d_tmo", d), 32'(tmo_o[d]), 32'd0);
         chk($sformatf("rst%0d_cd_d", d), 32'(d_o[d]), 32'd0);
         chk($sformatf("rst%0d_rdreqs", d), 32'(rdreqs_o[d]), 32'd0);
      end
      rdreq_s = 2'b00;

      // single request: latency and byte routing
      tx_s[0] = 4'b0100;
      tick();
      tx_s[0] = 4'b0000;
      chk("single_pending_c1", 32'(pend_o[0]), 32'h4);
      chk("single_nogrant_c1", 32'(grant_o[0]), 32'd0);
      tick();
      chk("single_start_c2", 32'(start_o[0]), 32'd1);
      chk("single_grant_c2", 32'(grant_o[0]), 32'h4);
      chk("single_pend_clr_c2", 32'(pend_o[0]), 32'd0);
      tick();
      chk("single_start_c3", 32'(start_o[0]), 32'd0);
      for (int j = 0; j < 3; j++) begin
         bytes_s[0][2*DW +: DW] = 8'hA1 + 8'(j);
         last_s[0][2] = (j == 2);
         rdreq_s[0]   = 1'b1;
         exp_d_q.push_back(8'hA1 + 8'(j));
         #1;
         e = exp_d_q.pop_front();
         chk($sformatf("single_cd_d%0d", j), 32'(d_o[0]), 32'(e));
         chk($sformatf("single_rdreqs%0d", j), 32'(rdreqs_o[0]), 32'h4);
         chk($sformatf("single_last%0d", j), 32'(last_o[0]), 32'(j == 2));
         tick();
      end
      rdreq_s[0] = 1'b0;
      last_s[0]  = '0;
      pck_s[0]   = 1'b1;
      tick();
      pck_s[0]   = 1'b0;
      chk("single_grant_end", 32'(grant_o[0]), 32'd0);
      chk("single_busy_end", 32'(busy_o[0]), 32'd0);

      // simultaneous starts, round-robin: 0,1,3
      do_reset();
      tx_s[0] = 4'b1011;
      exp_g_q.push_back(4'b0001);
      exp_g_q.push_back(4'b0010);
      exp_g_q.push_back(4'b1000);
      tick();
      tx_s[0] = 4'b0000;
      chk("rr_sim_pending", 32'(pend_o[0]), 32'hB);
      for (int p = 0; p < 3; p++) begin
         wait_grant(0, "rr_sim");
         finish_pkt(0, 4'b0000, "rr_sim");
      end

      // simultaneous starts, fixed priority, late start on 0 beats 3
      tx_s[1] = 4'b1011;
      exp_g_q.push_back(4'b0001);
      exp_g_q.push_back(4'b0010);
      tick();
      tx_s[1] = 4'b0000;
      wait_grant(1, "fp_sim");
      finish_pkt(1, 4'b0000, "fp_sim");
      wait_grant(1, "fp_sim");
      tx_s[1] = 4'b0001;
      exp_g_q.push_back(4'b0001);
      exp_g_q.push_back(4'b1000);
      tick();
      tx_s[1] = 4'b0000;
      finish_pkt(1, 4'b0000, "fp_sim");
      wait_grant(1, "fp_sim");
      finish_pkt(1, 4'b0000, "fp_sim");
      wait_grant(1, "fp_sim");
      finish_pkt(1, 4'b0000, "fp_sim");

      // fairness, round-robin: 0,1,0,1 with re-requests at pck_sent
      tx_s[0] = 4'b0011;
      exp_g_q.push_back(4'b0001);
      tick();
      tx_s[0] = 4'b0000;
      wait_grant(0, "rr_fair");
      exp_g_q.push_back(4'b0010);
      finish_pkt(0, 4'b0001, "rr_fair");
      wait_grant(0, "rr_fair");
      exp_g_q.push_back(4'b0001);
      finish_pkt(0, 4'b0010, "rr_fair");
      wait_grant(0, "rr_fair");
      exp_g_q.push_back(4'b0010);
      finish_pkt(0, 4'b0000, "rr_fair");
      wait_grant(0, "rr_fair");
      finish_pkt(0, 4'b0000, "rr_fair");

      // fairness, fixed priority: source 0 keeps winning
      tx_s[1] = 4'b0011;
      exp_g_q.push_back(4'b0001);
      tick();
      tx_s[1] = 4'b0000;
      wait_grant(1, "fp_fair");
      exp_g_q.push_back(4'b0001);
      finish_pkt(1, 4'b0001, "fp_fair");
      wait_grant(1, "fp_fair");
      exp_g_q.push_back(4'b0010);
      finish_pkt(1, 4'b0000, "fp_fair");
      wait_grant(1, "fp_fair");
      finish_pkt(1, 4'b0000, "fp_fair");

      // overrun flags while source 0 is active
      tx_s[0] = 4'b0011;
      exp_g_q.push_back(4'b0001);
      tick();
      tx_s[0] = 4'b0000;
      wait_grant(0, "ovr");
      tx_s[0] = 4'b0010;
      tick();
      tx_s[0] = 4'b0000;
      tick();
      tx_s[0] = 4'b0010;
      tick();
      tx_s[0] = 4'b0000;
      chk("ovr_set", 32'(ovr_o[0]), 32'h2);
      chk("ovr_pending", 32'(pend_o[0]), 32'h2);
      clr_s[0] = 1'b1;
      tick();
      clr_s[0] = 1'b0;
      chk("ovr_clear", 32'(ovr_o[0]), 32'd0);
      clr_s[0] = 1'b1;
      tx_s[0]  = 4'b0010;
      tick();
      tx_s[0]  = 4'b0000;
      chk("ovr_set_beats_clr", 32'(ovr_o[0]), 32'h2);
      tick();
      clr_s[0] = 1'b0;
      chk("ovr_clear2", 32'(ovr_o[0]), 32'd0);
      tx_s[0] = 4'b0001;
      tick();
      tx_s[0] = 4'b0000;
      chk("ovr_granted_pending", 32'(pend_o[0]), 32'h3);
      chk("ovr_granted_noflag", 32'(ovr_o[0]), 32'd0);
      finish_pkt(0, 4'b0000, "ovr");
      exp_g_q.push_back(4'b0010);
      wait_grant(0, "ovr_drain");
      finish_pkt(0, 4'b0000, "ovr_drain");
      exp_g_q.push_back(4'b0001);
      wait_grant(0, "ovr_drain");
      finish_pkt(0, 4'b0000, "ovr_drain");

      // stall timeout on source 2, then queued source 3 is served
      tx_s[0] = 4'b1100;
      exp_g_q.push_back(4'b0100);
      tick();
      tx_s[0] = 4'b0000;
      wait_grant(0, "tmo");
      hit = -1;
      for (int c = 1; c <= 20 && hit < 0; c++) begin
         tick();
         if (tmo_o[0]) hit = c;
      end
      chk("tmo_cycles", 32'(hit), 32'd16);
      chk("tmo_grant", 32'(grant_o[0]), 32'd0);
      chk("tmo_idle", 32'(busy_o[0]), 32'd0);
      tick();
      chk("tmo_pulse_1cyc", 32'(tmo_o[0]), 32'd0);
      exp_g_q.push_back(4'b1000);
      wait_grant(0, "tmo_next");
      finish_pkt(0, 4'b0000, "tmo_next");

      // reset in the middle of a packet with source 3 queued
      tx_s[0] = 4'b1001;
      exp_g_q.push_back(4'b0001);
      tick();
      tx_s[0] = 4'b0000;
      wait_grant(0, "mid");
      chk("mid_pending", 32'(pend_o[0]), 32'h8);
      tick();
      n_rst = 1'b0;
      rdreq_s[0] = 1'b1;
      tick();
      n_rst = 1'b1;
      chk("mid_grant", 32'(grant_o[0]), 32'd0);
      chk("mid_pending_clr", 32'(pend_o[0]), 32'd0);
      chk("mid_busy", 32'(busy_o[0]), 32'd0);
      chk("mid_start", 32'(start_o[0]), 32'd0);
      chk("mid_cd_d", 32'(d_o[0]), 32'd0);
      chk("mid_rdreqs", 32'(rdreqs_o[0]), 32'd0);
      rdreq_s[0] = 1'b0;
      starts = 0;
      repeat (6) begin
         tick();
         if (start_o[0]) starts++;
      end
      chk("mid_no_start", 32'(starts), 32'd0);
      tx_s[0] = 4'b0010;
      exp_g_q.push_back(4'b0010);
      tick();
      tx_s[0] = 4'b0000;
      wait_grant(0, "mid_new");
      finish_pkt(0, 4'b0000, "mid_new");

      chk("sb_drained", 32'(exp_g_q.size() + exp_d_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/usb_cd_arbiter.md
Name: usb_cd_arbiter

Overview:
- Parametrised N-source arbiter in front of usb_coder. Replaces the fixed two-source CRS/CCWB connector.
- Latches transmit requests from any number of byte sources, so simultaneous or back-to-back starts are queued rather than lost.
- Grants one source at a time under a fixed-priority or round-robin policy. Issues a single tx_start to the coder, then routes the granted source's data byte, last_byte and rdreq until pck_sent.
- Adds overrun flags and a stall timeout. Lives in the FCLK_OUT domain between the source buffers and usb_coder.

Parameters:
- N_SRC, 4, number of byte sources (2..8); index 0 = CRS, index 1 = CCWB by convention.
- DW, 8, byte width of the data path.
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- TMO_CYCLES, 4096, clk cycles without usb_rdreq in ACTIVE before abort; 0 disables the timeout.

Ports:
- clk  in  1  FTDI clock (FCLK_OUT).
- n_rst  in  1  reset; synchronous, active-low.
- tx_start_srcs  in  N_SRC  per-source one-cycle packet start pulses.
- src_bytes  in  N_SRC*DW  source data; source i occupies bits [i*DW +: DW].
- src_last_byte  in  N_SRC  per-source "current byte is last" flags.
- usb_rdreq  in  1  read strobe from usb_coder.
- pck_sent  in  1  one-cycle end-of-packet pulse from usb_coder.
- ovr_clr  in  1  clears all overrun flags.
- cd_tx_start  out  1  one-cycle start pulse to usb_coder.
- cd_d  out  DW  muxed byte to usb_coder.
- cd_last_byte  out  1  muxed last-byte flag.
- src_rdreqs  out  N_SRC  rdreq routed to the granted source only.
- grant  out  N_SRC  one-hot grant, i.e. the rdreqs mask; zero when idle.
- busy  out  1  high in START and ACTIVE.
- pending  out  N_SRC  queued requests.
- overrun  out  N_SRC  sticky: a start arrived while that source was already pending.
- tmo_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (n_rst=0 at a clk edge) takes priority over everything else and forces:
  - state=IDLE;
  - grant=0, pending=0, overrun=0;
  - RR pointer = N_SRC-1, so source 0 is searched first;
  - cd_tx_start=0, tmo_err=0, timeout counter=0.
- Reset mid-packet drops the grant immediately; the coder is reset by the same n_rst.
- Pending register update:
  - pending_next = (pending & ~take) | tx_start_srcs, where take is the one-hot being granted this cycle.
  - overrun[i] is set when tx_start_srcs[i] & pending[i] & ~take[i].
  - ovr_clr clears overrun; a set in the same cycle wins over the clear.
- A start from the currently granted source during ACTIVE is queued as pending, not flagged as overrun.
- States:
  - IDLE: if pending!=0, choose a winner:
    - RR_EN=1: first set bit searching upward from pointer+1, wrapping modulo N_SRC.
    - RR_EN=0: lowest set index.
    - Register grant=winner, clear that pending bit, update pointer to the winner, go to START.
  - START: cd_tx_start=1 for exactly this cycle, then go to ACTIVE. pck_sent is ignored here.
  - ACTIVE: route the granted source.
    - On pck_sent: grant=0, go to IDLE.
    - If TMO_CYCLES!=0 and the counter reaches TMO_CYCLES-1 with no usb_rdreq: grant=0, tmo_err=1 for one cycle, go to IDLE.
    - The counter clears on every usb_rdreq and on entry to ACTIVE.
- Latency:
  - Start pulse in cycle 0 → pending visible in cycle 1 → grant and cd_tx_start in cycle 2 → ACTIVE in cycle 3.
  - IDLE lasts at least one cycle between packets.
- Combinational outputs from registered grant:
  - cd_d = src_bytes of the granted source; 0 when grant=0.
  - cd_last_byte = src_last_byte[granted] & (state==ACTIVE).
  - src_rdreqs = grant & {N_SRC{usb_rdreq}}.
  - No source sees rdreq while ungranted.
- pck_sent or usb_rdreq in IDLE: ignored.
- Grant is always one-hot or zero; no X-propagation on an unused mux input.

Decomposition:
- Shared package usb_cd_pkg holds:
  - state encoding (IDLE=2'd0, START=2'd1, ACTIVE=2'd2);
  - source index constants (SRC_CRS=0, SRC_CCWB=1);
  - the default DW.
- One natural sub-module: rr_pick — a combinational N-bit round-robin/priority picker with inputs req, ptr, rr_en and output one-hot.
- The pending/overrun registers, FSM, timeout counter and output mux stay in the top module.

Test Plan:
- Single request: N_SRC=4, pulse tx_start_srcs=4'b0100 in cycle 0 → pending=0100 in cycle 1; cd_tx_start and grant=0100 in cycle 2. Then drive 3 usb_rdreq with src_bytes[2]=A1,A2,A3 → cd_d follows, src_rdreqs=0100 only. pck_sent → grant=0, busy=0.
- Simultaneous starts with RR_EN=1: tx_start_srcs=4'b1011 in one cycle → grants in order 0,1,3, with each transition on pck_sent. With RR_EN=0 the order is also 0,1,3, but a new start on source 0 during packet 1 is served before 3.
- Round-robin fairness: sources 0 and 1 re-request at every pck_sent → grants alternate 0,1,0,1; under RR_EN=0 source 0 always wins.
- Overrun: tx_start_srcs[1] pulses twice while source 1 is pending and source 0 is active → overrun=0010 and pending=0010. ovr_clr → overrun=0. A start on granted source 0 during ACTIVE → pending[0]=1, overrun[0]=0.
- Timeout: TMO_CYCLES=16, grant source 2, no usb_rdreq for 16 cycles → tmo_err pulses once, grant=0, IDLE; the queued source 3 is then granted.
- Reset mid-packet: n_rst=0 for one cycle during ACTIVE with pending=1000 → on the next cycle all outputs are 0 and the state is IDLE; no cd_tx_start is issued until a new request arrives.
